// File: rtl/matmul_input_mem_responder_if.sv
// Host-loader and FSM read-port bundle for matmul_input_mem_responder.
// The parity_flip_in/parity_err pair exists only when MEM_RESP_PARITY_EN is defined.
interface matmul_input_mem_responder_if #(
  parameter int PORT_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = $clog2(DEPTH) + 1
);
  logic                  host_load_start;
  logic [LEN_W-1:0]      host_load_len;
  logic                  host_wr_valid;
  logic [PORT_WIDTH-1:0] host_wr_data;
  logic                  host_wr_ready;
  logic                  inputs_rdy;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wr_en;
  logic [PORT_WIDTH-1:0] mem_rd_data;
  logic                  addr_err;
  logic                  wr_err;
`ifdef MEM_RESP_PARITY_EN
  logic                  parity_flip_in;
  logic                  parity_err;
`endif

  modport master (
    output host_load_start, host_load_len, host_wr_valid, host_wr_data,
    output mem_addr, mem_wr_en,
`ifdef MEM_RESP_PARITY_EN
    output parity_flip_in,
    input  parity_err,
`endif
    input  host_wr_ready, inputs_rdy, mem_rd_data, addr_err, wr_err
  );

  modport slave (
    input  host_load_start, host_load_len, host_wr_valid, host_wr_data,
    input  mem_addr, mem_wr_en,
`ifdef MEM_RESP_PARITY_EN
    input  parity_flip_in,
    output parity_err,
`endif
    output host_wr_ready, inputs_rdy, mem_rd_data, addr_err, wr_err
  );
endinterface

// File: rtl/matmul_input_mem_responder.sv
// Input-RAM responder for the matmul FSM: host loads words, FSM reads them back with fixed latency.
// Optional per-word even parity is enabled by defining MEM_RESP_PARITY_EN.
module matmul_input_mem_responder #(
  parameter int PORT_WIDTH         = 64,
  parameter int DEPTH              = 256,
  parameter int MEM_ACCESS_LATENCY = 2,
  parameter int ADDR_W             = 32
) (
  input  logic clk,
  input  logic rst,
  matmul_input_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam int LAT   = MEM_ACCESS_LATENCY;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, len_q;
  logic                  addr_err_q, wr_err_q;
  logic [PORT_WIDTH-1:0] mem [DEPTH];
  logic [PORT_WIDTH-1:0] rd_data_p [LAT];
  logic                  wr_ready, wr_fire, rd_en, addr_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic [PORT_WIDTH-1:0] rd_word;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  endfunction

  assign wr_ready = (state_q == LOAD) && (cnt_q < len_q);
  // A restart on the final write cycle discards that word.
  assign wr_fire  = bus.host_wr_valid && wr_ready && !bus.host_load_start;
  assign rd_en    = (state_q == READY) && !bus.host_load_start;
  assign addr_ok  = bus.mem_addr < ADDR_W'(DEPTH);
  assign rd_idx   = bus.mem_addr[IDX_W-1:0];
  assign rd_word  = addr_ok ? mem[rd_idx] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.host_load_start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: if ((cnt_q == len_q) || (wr_fire && (cnt_q + LEN_W'(1) == len_q)))
                state_d = READY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      len_q      <= '0;
      addr_err_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else if (bus.host_load_start) begin
      cnt_q      <= '0;
      len_q      <= clamp_len(bus.host_load_len);
      addr_err_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      if (wr_fire) cnt_q <= cnt_q + LEN_W'(1);
      if (state_q == READY) begin
        addr_err_q <= addr_err_q | !addr_ok;
        wr_err_q   <= wr_err_q | bus.mem_wr_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[cnt_q[IDX_W-1:0]] <= bus.host_wr_data;
  end

  // Read pipeline stage 0 samples mem_addr; stage LAT-1 drives mem_rd_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) rd_data_p[i] <= '0;
    end else if (bus.host_load_start) begin
      for (int i = 0; i < LAT; i++) rd_data_p[i] <= '0;
    end else begin
      rd_data_p[0] <= rd_en ? rd_word : '0;
      for (int i = 1; i < LAT; i++) rd_data_p[i] <= rd_data_p[i-1];
    end
  end

  assign bus.host_wr_ready = wr_ready;
  assign bus.inputs_rdy    = (state_q == READY);
  assign bus.mem_rd_data   = rd_data_p[LAT-1];
  assign bus.addr_err      = addr_err_q;
  assign bus.wr_err        = wr_err_q;

`ifdef MEM_RESP_PARITY_EN
  logic par_mem [DEPTH];
  logic par_err_p [LAT];
  logic rd_par_bad;

  always_ff @(posedge clk) begin
    if (wr_fire) par_mem[cnt_q[IDX_W-1:0]] <= (^bus.host_wr_data) ^ bus.parity_flip_in;
  end

  assign rd_par_bad = rd_en && addr_ok && ((^rd_word) != par_mem[rd_idx]);

  // Parity flag travels in lockstep with the read data pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) par_err_p[i] <= 1'b0;
    end else if (bus.host_load_start) begin
      for (int i = 0; i < LAT; i++) par_err_p[i] <= 1'b0;
    end else begin
      par_err_p[0] <= rd_par_bad;
      for (int i = 1; i < LAT; i++) par_err_p[i] <= par_err_p[i-1];
    end
  end

  assign bus.parity_err = par_err_p[LAT-1];
`endif
endmodule

// File: tb/tb_matmul_input_mem_responder.sv
// Self-checking bench for matmul_input_mem_responder: vector table, corner sequences, random reads.
module tb_matmul_input_mem_responder;
  localparam int PW = 64, DEPTH = 256, LAT = 2, AW = 32, LEN_W = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matmul_input_mem_responder_if #(.PORT_WIDTH(PW), .DEPTH(DEPTH), .ADDR_W(AW)) bus ();

  matmul_input_mem_responder #(
    .PORT_WIDTH(PW), .DEPTH(DEPTH), .MEM_ACCESS_LATENCY(LAT), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr_en;
    logic [PW-1:0] data;
  } rd_vec_t;

  localparam int NV = 8;
  rd_vec_t       tbl [NV];
  logic [PW-1:0] model_mem [DEPTH];
  logic [PW-1:0] words [4];
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.host_load_start = 1'b0;
    bus.host_load_len   = '0;
    bus.host_wr_valid   = 1'b0;
    bus.host_wr_data    = '0;
    bus.mem_addr        = '0;
    bus.mem_wr_en       = 1'b0;
`ifdef MEM_RESP_PARITY_EN
    bus.parity_flip_in  = 1'b0;
`endif
  endtask

  task automatic load_random(input int len);
    int exp_n, wi;
    logic fire;
    exp_n = (len > DEPTH) ? DEPTH : len;
    wi = 0;
    bus.host_load_start = 1'b1;
    bus.host_load_len   = LEN_W'(len);
    cyc();
    bus.host_load_start = 1'b0;
    for (int c = 0; c < 2000 && !bus.inputs_rdy; c++) begin
      bus.host_wr_valid = ($urandom_range(0, 3) != 0);
      bus.host_wr_data  = {$urandom, $urandom};
      fire = bus.host_wr_valid && bus.host_wr_ready;
      if (fire && wi < DEPTH) model_mem[wi] = bus.host_wr_data;
      if (fire) wi++;
      cyc();
    end
    bus.host_wr_valid = 1'b0;
    chk("rand_load_inputs_rdy", 64'(bus.inputs_rdy), 64'd1);
    chk("rand_load_word_count", 64'(wi), 64'(exp_n));
    chk("rand_load_ready_low", 64'(bus.host_wr_ready), 64'd0);
  endtask

  task automatic rand_reads(input int n, input int max_addr);
    logic [PW-1:0] q [$];
    logic [PW-1:0] e;
    logic [AW-1:0] a;
    logic          exp_aerr, exp_werr;
    exp_aerr = 1'b0;
    exp_werr = 1'b0;
    for (int j = 0; j < n + LAT - 1; j++) begin
      if (j < n) begin
        a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h100) : AW'($urandom_range(0, max_addr - 1));
        bus.mem_wr_en = ($urandom_range(0, 15) == 0);
      end else begin
        a = '0;
        bus.mem_wr_en = 1'b0;
      end
      bus.mem_addr = a;
      e = (a < DEPTH) ? model_mem[a[7:0]] : '0;
      q.push_back(e);
      exp_aerr = exp_aerr | (a >= DEPTH);
      exp_werr = exp_werr | bus.mem_wr_en;
      cyc();
      if (q.size() == LAT) begin
        e = q.pop_front();
        chk("rand_rd_data", bus.mem_rd_data, e);
      end
      chk("rand_addr_err", 64'(bus.addr_err), 64'(exp_aerr));
      chk("rand_wr_err", 64'(bus.wr_err), 64'(exp_werr));
`ifdef MEM_RESP_PARITY_EN
      chk("rand_parity_quiet", 64'(bus.parity_err), 64'd0);
`endif
    end
    bus.mem_wr_en = 1'b0;
  endtask

  initial begin
    int wi, rdy_cycles, k;
    logic exp_aerr, exp_werr;

    words = '{64'h11, 64'h22, 64'h33, 64'h44};
    tbl[0] = '{32'd0,          1'b0, 64'h11};
    tbl[1] = '{32'd1,          1'b0, 64'h22};
    tbl[2] = '{32'd2,          1'b0, 64'h33};
    tbl[3] = '{32'd3,          1'b0, 64'h44};
    tbl[4] = '{32'd256,        1'b0, 64'h0};
    tbl[5] = '{32'd2,          1'b1, 64'h33};
    tbl[6] = '{32'd2,          1'b0, 64'h33};
    tbl[7] = '{32'hFFFF_FFFF,  1'b0, 64'h0};

    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_host_wr_ready", 64'(bus.host_wr_ready), 64'd0);
    chk("reset_inputs_rdy", 64'(bus.inputs_rdy), 64'd0);
    chk("reset_mem_rd_data", bus.mem_rd_data, 64'd0);
    chk("reset_addr_err", 64'(bus.addr_err), 64'd0);
    chk("reset_wr_err", 64'(bus.wr_err), 64'd0);

    rst = 1'b1;
    bus.host_wr_valid = 1'b1;
    cyc();
    chk("empty_ignores_valid", 64'(bus.host_wr_ready), 64'd0);
    chk("empty_not_rdy", 64'(bus.inputs_rdy), 64'd0);

    // Load four words with valid held high.
    bus.host_load_start = 1'b1;
    bus.host_load_len   = LEN_W'(4);
    cyc();
    bus.host_load_start = 1'b0;
    wi = 0;
    rdy_cycles = 0;
    for (int c = 0; c < 10 && wi < 4; c++) begin
      bus.host_wr_data = words[wi];
      chk("load4_not_rdy_yet", 64'(bus.inputs_rdy), 64'd0);
      if (bus.host_wr_ready) begin
        rdy_cycles++;
        model_mem[wi] = words[wi];
        wi++;
      end
      cyc();
    end
    chk("load4_ready_cycles", 64'(rdy_cycles), 64'd4);
    chk("load4_inputs_rdy", 64'(bus.inputs_rdy), 64'd1);
    chk("load4_ready_after", 64'(bus.host_wr_ready), 64'd0);
    bus.host_wr_valid = 1'b0;

    // Vector table, applied back-to-back.
    exp_aerr = 1'b0;
    exp_werr = 1'b0;
    for (int j = 0; j < NV + LAT - 1; j++) begin
      if (j < NV) begin
        bus.mem_addr  = tbl[j].addr;
        bus.mem_wr_en = tbl[j].wr_en;
        exp_aerr = exp_aerr | (tbl[j].addr >= DEPTH);
        exp_werr = exp_werr | tbl[j].wr_en;
      end else begin
        bus.mem_addr  = '0;
        bus.mem_wr_en = 1'b0;
      end
      cyc();
      k = j - (LAT - 1);
      if (k >= 0 && k < NV) chk($sformatf("tbl_rd_data[%0d]", k), bus.mem_rd_data, tbl[k].data);
      chk("tbl_addr_err", 64'(bus.addr_err), 64'(exp_aerr));
      chk("tbl_wr_err", 64'(bus.wr_err), 64'(exp_werr));
    end
    bus.mem_wr_en = 1'b0;
    cyc();
    chk("addr_err_sticky", 64'(bus.addr_err), 64'd1);
    chk("wr_err_sticky", 64'(bus.wr_err), 64'd1);

    // Restart with len=0 while reads are in flight.
    bus.mem_addr = 32'd1;
    cyc();
    bus.mem_addr = 32'd3;
    cyc();
    bus.host_load_start = 1'b1;
    bus.host_load_len   = '0;
    bus.mem_addr        = 32'd2;
    cyc();
    bus.host_load_start = 1'b0;
    chk("restart_flush_data", bus.mem_rd_data, 64'd0);
    chk("restart_rdy_drop", 64'(bus.inputs_rdy), 64'd0);
    chk("restart_addr_err_clr", 64'(bus.addr_err), 64'd0);
    chk("restart_wr_err_clr", 64'(bus.wr_err), 64'd0);
    cyc();
    chk("restart_rdy_back", 64'(bus.inputs_rdy), 64'd1);
    chk("restart_data_zero1", bus.mem_rd_data, 64'd0);
    cyc();
    chk("restart_data_zero2", bus.mem_rd_data, 64'd0);
    cyc();
    chk("restart_first_read", bus.mem_rd_data, 64'h33);

    // Restart on the final write cycle: the final word is dropped.
    bus.host_load_start = 1'b1;
    bus.host_load_len   = LEN_W'(2);
    cyc();
    bus.host_load_start = 1'b0;
    bus.host_wr_valid   = 1'b1;
    bus.host_wr_data    = 64'hAAAA;
    cyc();
    model_mem[0] = 64'hAAAA;
    bus.host_wr_data    = 64'hBBBB;
    bus.host_load_start = 1'b1;
    bus.host_load_len   = LEN_W'(1);
    cyc();
    bus.host_load_start = 1'b0;
    chk("collide_still_loading", 64'(bus.host_wr_ready), 64'd1);
    chk("collide_not_rdy", 64'(bus.inputs_rdy), 64'd0);
    bus.host_wr_data = 64'hCCCC;
    cyc();
    model_mem[0] = 64'hCCCC;
    bus.host_wr_valid = 1'b0;
    chk("collide_reload_rdy", 64'(bus.inputs_rdy), 64'd1);
    bus.mem_addr = 32'd0;
    cyc();
    bus.mem_addr = 32'd1;
    cyc();
    chk("collide_addr0", bus.mem_rd_data, model_mem[0]);
    cyc();
    chk("collide_addr1_kept", bus.mem_rd_data, model_mem[1]);

    // Random loads with bubbles, then random reads against the model.
    load_random(300);
    rand_reads(150, DEPTH);
    begin
      int len;
      len = $urandom_range(1, 24);
      load_random(len);
      rand_reads(150, len);
    end

`ifdef MEM_RESP_PARITY_EN
    bus.host_load_start = 1'b1;
    bus.host_load_len   = LEN_W'(1);
    cyc();
    bus.host_load_start = 1'b0;
    bus.host_wr_valid   = 1'b1;
    bus.host_wr_data    = 64'h5;
    bus.parity_flip_in  = 1'b1;
    cyc();
    bus.host_wr_valid   = 1'b0;
    bus.parity_flip_in  = 1'b0;
    chk("par_load_rdy", 64'(bus.inputs_rdy), 64'd1);
    bus.mem_addr = 32'd0;
    cyc();
    bus.mem_addr = 32'(DEPTH);
    chk("par_err_early", 64'(bus.parity_err), 64'd0);
    cyc();
    chk("par_rd_data", bus.mem_rd_data, 64'h5);
    chk("par_err_pulse", 64'(bus.parity_err), 64'd1);
    cyc();
    chk("par_err_end", 64'(bus.parity_err), 64'd0);
`endif

    // Asynchronous reset mid-read.
    bus.mem_addr = 32'd1;
    cyc();
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_data", bus.mem_rd_data, 64'd0);
    chk("async_rst_rdy", 64'(bus.inputs_rdy), 64'd0);
    chk("async_rst_addr_err", 64'(bus.addr_err), 64'd0);
    chk("async_rst_wr_err", 64'(bus.wr_err), 64'd0);
    #3 rst = 1'b1;
    cyc();
    cyc();
    chk("post_rst_empty_rdy", 64'(bus.inputs_rdy), 64'd0);
    chk("post_rst_empty_wr_ready", 64'(bus.host_wr_ready), 64'd0);
    chk("post_rst_data", bus.mem_rd_data, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
